// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding,
// port indices and the round-robin pick helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

  localparam logic ARB_P_DATA  = 1'b0;
  localparam logic ARB_P_FETCH = 1'b1;

  // Two-way round-robin: a lone requester wins; on a tie the port that
  // was not granted last time wins. Result is meaningless when req == 0.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    logic win;
    if (req == 2'b11) begin
      win = ~last;
    end else if (req[1]) begin
      win = ARB_P_FETCH;
    end else begin
      win = ARB_P_DATA;
    end
    return win;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer sharing the cache controller user port between the
// CPU data port (0) and the instruction-fetch port (1). One transaction
// in flight, round-robin priority, sticky watchdog on a stuck controller.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst_x,
  input  logic        p0_req,
  input  logic        p1_req,
  input  logic        p0_we,
  input  logic        p1_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p0_wdata,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p0_mask,
  input  logic [3:0]  p1_mask,
  output logic        p0_gnt,
  output logic        p1_gnt,
  output logic        p0_done,
  output logic        p1_done,
  output logic [31:0] p0_rdata,
  output logic [31:0] p1_rdata,
  output logic        m_rd_en,
  output logic        m_wr_en,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_mask,
  input  logic [31:0] m_rdata,
  input  logic        m_busy,
  output logic        err
);

  localparam int             CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);

  arb_state_e       state_q, state_d;
  logic             win_q, win_d;
  logic             last_q, last_d;
  logic             we_q, we_d;
  logic [31:0]      m_addr_q, m_addr_d;
  logic [31:0]      m_wdata_q, m_wdata_d;
  logic [3:0]       m_mask_q, m_mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [31:0]      p0_rdata_q, p0_rdata_d;
  logic [31:0]      p1_rdata_q, p1_rdata_d;
  logic             m_rd_en_q, m_rd_en_d;
  logic             m_wr_en_q, m_wr_en_d;
  logic             p0_done_q, p0_done_d;
  logic             p1_done_q, p1_done_d;

  logic             any_s;
  logic             pick_s;
  logic [CNT_W-1:0] cnt_inc_s;

  assign any_s     = p0_req | p1_req;
  assign pick_s    = rr_pick({p1_req, p0_req}, last_q);
  // Saturating increment so the watchdog can never wrap back to zero.
  assign cnt_inc_s = (cnt_q >= CNT_LIM) ? cnt_q : (cnt_q + CNT_W'(1));

  // Next-state, grant and datapath-load decisions for the transaction FSM.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    last_d     = last_q;
    we_d       = we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_mask_d   = m_mask_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
    m_rd_en_d  = 1'b0;
    m_wr_en_d  = 1'b0;
    p0_done_d  = 1'b0;
    p1_done_d  = 1'b0;
    p0_gnt     = 1'b0;
    p1_gnt     = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (any_s) begin
          if (pick_s == ARB_P_DATA) begin
            p0_gnt = 1'b1;
          end else begin
            p1_gnt = 1'b1;
          end
          win_d     = pick_s;
          last_d    = pick_s;
          we_d      = pick_s ? p1_we    : p0_we;
          m_addr_d  = pick_s ? p1_addr  : p0_addr;
          m_wdata_d = pick_s ? p1_wdata : p0_wdata;
          m_mask_d  = pick_s ? p1_mask  : p0_mask;
          // Strobe is registered so it appears exactly in the ISSUE cycle.
          m_rd_en_d = ~(pick_s ? p1_we : p0_we);
          m_wr_en_d =  (pick_s ? p1_we : p0_we);
          state_d   = ARB_ISSUE;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_ISSUE: begin
        // Controller is still leaving idle here, so m_busy is not trusted.
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        cnt_d = cnt_inc_s;
        if (!m_busy) begin
          if (!we_q) begin
            if (win_q == ARB_P_DATA) begin
              p0_rdata_d = m_rdata;
            end else begin
              p1_rdata_d = m_rdata;
            end
          end else begin
            p0_rdata_d = p0_rdata_q;
          end
          p0_done_d = (win_q == ARB_P_DATA);
          p1_done_d = (win_q == ARB_P_FETCH);
          state_d   = ARB_DONE;
        end else if (cnt_inc_s >= CNT_LIM) begin
          err_d = 1'b1;
          if (!we_q) begin
            if (win_q == ARB_P_DATA) begin
              p0_rdata_d = ERR_DATA;
            end else begin
              p1_rdata_d = ERR_DATA;
            end
          end else begin
            p0_rdata_d = p0_rdata_q;
          end
          p0_done_d = (win_q == ARB_P_DATA);
          p1_done_d = (win_q == ARB_P_FETCH);
          state_d   = ARB_DONE;
        end else begin
          state_d = ARB_WAIT;
        end
      end
      ARB_DONE: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and datapath registers; last_gnt resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q    <= ARB_IDLE;
      win_q      <= ARB_P_DATA;
      last_q     <= ARB_P_FETCH;
      we_q       <= 1'b0;
      m_addr_q   <= 32'h0000_0000;
      m_wdata_q  <= 32'h0000_0000;
      m_mask_q   <= 4'h0;
      cnt_q      <= {CNT_W{1'b0}};
      err_q      <= 1'b0;
      p0_rdata_q <= 32'h0000_0000;
      p1_rdata_q <= 32'h0000_0000;
      m_rd_en_q  <= 1'b0;
      m_wr_en_q  <= 1'b0;
      p0_done_q  <= 1'b0;
      p1_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      last_q     <= last_d;
      we_q       <= we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_mask_q   <= m_mask_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
      m_rd_en_q  <= m_rd_en_d;
      m_wr_en_q  <= m_wr_en_d;
      p0_done_q  <= p0_done_d;
      p1_done_q  <= p1_done_d;
    end
  end

  assign p0_done  = p0_done_q;
  assign p1_done  = p1_done_q;
  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;
  assign m_rd_en  = m_rd_en_q;
  assign m_wr_en  = m_wr_en_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign m_mask   = m_mask_q;
  assign err      = err_q;

endmodule
